irq_controller: RTL

//  External interrupt controller; source end of the eip/eip_reply pair consumed by the CSR/privilege unit.

---
 rtl/irq_controller_pkg.sv | 18 +
 rtl/irq_sync_edge.sv | 28 ++
 rtl/irq_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// CLAIM layout and FSM state encoding.
package irq_controller_pkg;

  localparam logic [1:0] IrqPending = 2'd0;
  localparam logic [1:0] IrqEnable  = 2'd1;
  localparam logic [1:0] IrqEdge    = 2'd2;
  localparam logic [1:0] IrqClaim   = 2'd3;

  localparam int unsigned ClaimValidBit = 31;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAssert = 2'b01,
    StHold   = 2'b11
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line 2-flop synchronizer followed by a prev flop; provides the
// synchronized level and a one-cycle rising-edge strobe.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= irq;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// External interrupt controller: latches device IRQs as pending, raises eip for
// the lowest enabled pending source and records the claimed ID on eip_reply.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  localparam int unsigned IDW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic [3:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo,
  output logic            eip,
  input  logic            eip_reply
);

  logic [NSRC-1:0] level, rise;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .irq   (irq[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            eip_q, eip_d;
  logic            claim_valid_q, claim_valid_d;
  logic [IDW-1:0]  claim_id_q, claim_id_d;

  logic            wr_pend, wr_en, wr_edge, wr_claim;
  logic [NSRC-1:0] set_mask, w1c_mask, reply_clr, req;
  logic [IDW-1:0]  low_id;
  logic            reply_done;
  logic            unused_bits;

  assign wr_pend  = we && (a[3:2] == IrqPending);
  assign wr_en    = we && (a[3:2] == IrqEnable);
  assign wr_edge  = we && (a[3:2] == IrqEdge);
  assign wr_claim = we && (a[3:2] == IrqClaim);

  assign set_mask = (edge_q & rise) | (~edge_q & level);
  assign w1c_mask = wr_pend ? d[NSRC-1:0] : '0;
  assign req      = pend_q & en_q;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    low_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) low_id = IDW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    eip_d      = eip_q;
    reply_clr  = '0;
    reply_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          id_d    = low_id;
          eip_d   = 1'b1;
          state_d = StAssert;
        end
      end
      StAssert: begin
        if (eip_reply) begin
          eip_d         = 1'b0;
          reply_clr[id_q] = 1'b1;
          reply_done    = 1'b1;
          state_d       = StHold;
        end
      end
      StHold: begin
        if (!eip_reply) state_d = StIdle;
      end
      default: begin
        eip_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    // New sets win over both W1C and reply clears on the same bit.
    pend_d        = (pend_q & ~w1c_mask & ~reply_clr) | set_mask;
    en_d          = wr_en ? d[NSRC-1:0] : en_q;
    edge_d        = wr_edge ? d[NSRC-1:0] : edge_q;
    claim_valid_d = claim_valid_q;
    claim_id_d    = claim_id_q;
    if (wr_claim) claim_valid_d = 1'b0;
    if (reply_done) begin
      claim_valid_d = 1'b1;
      claim_id_d    = id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pend_q        <= '0;
      en_q          <= '0;
      edge_q        <= '0;
      id_q          <= '0;
      eip_q         <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      en_q          <= en_d;
      edge_q        <= edge_d;
      id_q          <= id_d;
      eip_q         <= eip_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  always_comb begin
    spo = '0;
    case (a[3:2])
      IrqPending: spo[NSRC-1:0] = pend_q;
      IrqEnable:  spo[NSRC-1:0] = en_q;
      IrqEdge:    spo[NSRC-1:0] = edge_q;
      default: begin
        spo[ClaimValidBit] = claim_valid_q;
        spo[IDW-1:0]       = claim_id_q;
      end
    endcase
  end

  assign eip         = eip_q;
  assign unused_bits = ^{a[1:0], d};

endmodule
